mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single memory-unit port (10-bit word address, 32-bit data, write enable) between two requesters.
//   The requesters are the instruction-fetch (IF, read-only) and the load/store unit (LS, read/write).
//   Sits between the core pipeline and the memory unit (RAM + MMIO decode).
//   Sequences each access as one issue cycle plus a fixed read wait.
//   Fixed LS priority, with a starvation guard that forces an IF grant.
// PARAMETERS
//   ADDR_W      10  memory word-address width
//   DATA_W      32  data width
//   RD_LAT      1   cycles from issue to valid mem_rdata; legal 1..4
//   STARVE_MAX  4   consecutive LS grants while if_req is high before IF is forced; legal >=1
// PORTS
//   clk        in   1       single clock, rising edge
//   rst        in   1       synchronous reset, active-high
//   if_req     in   1       fetch read request
//   if_addr    in   ADDR_W  fetch address
//   if_gnt     out  1       fetch request accepted (1-cycle pulse)
//   if_rvalid  out  1       if_rdata valid (1-cycle pulse)
//   if_rdata   out  DATA_W  fetch read data
//   ls_req     in   1       load/store request
//   ls_we      in   1       1=store, 0=load
//   ls_addr    in   ADDR_W  load/store address
//   ls_wdata   in   DATA_W  store data
//   ls_gnt     out  1       LS request accepted (1-cycle pulse)
//   ls_rvalid  out  1       ls_rdata valid (1-cycle pulse, loads only)
//   ls_rdata   out  DATA_W  load data
//   mem_addr   out  ADDR_W  to memory-unit address
//   mem_wdata  out  DATA_W  to memory-unit data_in
//   mem_we     out  1       to memory-unit write_enable
//   mem_rdata  in   DATA_W  from memory-unit data_out
//   busy       out  1       state != IDLE
// BEHAVIOUR
//   Reset: at the clk edge with rst=1, all outputs go to 0, state goes to IDLE and starve_cnt goes to 0.
//     rst mid-transaction abandons it; no gnt or rvalid is produced for it.
//   FSM: IDLE -> ISSUE -> (write: IDLE) | (read: WAIT -> RESP -> IDLE).
//   IDLE
//     If any req is high, pick the winner; register its addr, we and wdata; go to ISSUE.
//     Otherwise stay in IDLE.
//   Winner selection
//     IF wins if if_req && (!ls_req || starve_cnt == STARVE_MAX).
//     Otherwise LS wins.
//   ISSUE (exactly 1 cycle)
//     Drive mem_addr and mem_wdata from the captured values.
//     mem_we = captured we; IF is always we=0.
//     The winner's gnt pulses high in this cycle.
//     A req dropped after capture does not cancel the transaction.
//   WAIT
//     Holds mem_addr stable and mem_we=0.
//     Counts RD_LAT cycles from ISSUE.
//     At cycle ISSUE+RD_LAT, samples mem_rdata into the winner's rdata register.
//   RESP (1 cycle)
//     The winner's rvalid is high; its rdata holds the sampled word until that requester's next RESP.
//     Total latency: gnt at ISSUE, rvalid at ISSUE+RD_LAT+1.
//   Outside ISSUE and WAIT: mem_addr=0, mem_wdata=0, mem_we=0.
//   starve_cnt
//     +1 (saturating at STARVE_MAX) on each LS grant while if_req is high.
//     Cleared on an IF grant, or in any IDLE cycle with if_req=0.
//   Throughput
//     Store: 1 per 2 cycles.
//     Load/fetch: 1 per RD_LAT+3 cycles.
//     Only one transaction is outstanding at a time.
//   Never both gnts in the same cycle, and never both rvalids in the same cycle.
//   ls_rvalid is never asserted for a store.
//   Address width: addresses pass through unmodified; no wrap or offset arithmetic.
// TESTING
//   1. RD_LAT=1; if_req, if_addr=0x010; memory model returns 0xDEADBEEF.
//      -> if_gnt at T+1, mem_addr=0x010, if_rvalid at T+3 with if_rdata=0xDEADBEEF.
//   2. ls_req, ls_we=1, addr=0x3FF, wdata=0x12345678.
//      -> single-cycle mem_we with mem_addr=0x3FF; ls_gnt in the same cycle; no ls_rvalid; busy=0 the next cycle.
//   3. if_req and ls_req (load) rise together.
//      -> ls_gnt first, if_gnt on the next ISSUE; each rdata is routed only to its own requester.
//   4. STARVE_MAX=4; both reqs held high.
//      -> grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
//   5. rst pulsed during WAIT.
//      -> the next cycle all outputs are 0, no rvalid appears, and the following load returns correct data.
//   6. RD_LAT=3.
//      -> mem_rdata is sampled exactly at ISSUE+3; a wrong value driven at ISSUE+2 is not captured.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (read-only)
// and the load/store unit. Load/store has priority; a starvation counter forces
// a fetch grant after STARVE_MAX consecutive load/store grants taken while the
// fetch request was waiting. One transaction is outstanding at a time.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  // RD_LAT is limited to 1..4, so a 3-bit wait counter is enough.
  localparam logic [2:0] LAT_LIM = 3'(RD_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic [2:0]       lat_cnt;
  logic             cur_we;
  logic             cur_is_if;
  logic             if_wins;

  // Fetch wins when load/store is absent or fetch has waited long enough.
  always_comb begin
    if_wins = if_req && (!ls_req || (starve_cnt == STARVE_LIM));
  end

  // Access sequencer: IDLE -> ISSUE -> (store: IDLE | read: WAIT -> RESP -> IDLE).
  // All ports are registered; gnt/rvalid are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_cnt    <= 3'd0;
      cur_we     <= 1'b0;
      cur_is_if  <= 1'b0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      ls_gnt     <= 1'b0;
      ls_rvalid  <= 1'b0;
      ls_rdata   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || ls_req) begin
            state <= ISSUE;
            busy  <= 1'b1;
            if (if_wins) begin
              cur_is_if  <= 1'b1;
              cur_we     <= 1'b0;
              mem_addr   <= if_addr;
              mem_wdata  <= '0;
              mem_we     <= 1'b0;
              if_gnt     <= 1'b1;
              starve_cnt <= '0;
            end else begin
              cur_is_if <= 1'b0;
              cur_we    <= ls_we;
              mem_addr  <= ls_addr;
              mem_wdata <= ls_wdata;
              mem_we    <= ls_we;
              ls_gnt    <= 1'b1;
              if (!if_req) begin
                starve_cnt <= '0;
              end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
              end else begin
                starve_cnt <= starve_cnt;
              end
            end
          end else begin
            // Nobody asking: fetch is not waiting, so the guard restarts.
            starve_cnt <= '0;
            busy       <= 1'b0;
          end
        end
        ISSUE: begin
          mem_we <= 1'b0;
          if (cur_we) begin
            state     <= IDLE;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end else begin
            // Address stays on the port while the memory produces data.
            state   <= WAIT;
            lat_cnt <= 3'd1;
          end
        end
        WAIT: begin
          if (lat_cnt == LAT_LIM) begin
            state     <= RESP;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (cur_is_if) begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end else begin
              ls_rdata  <= mem_rdata;
              ls_rvalid <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios on an RD_LAT=1 instance
// (with a synchronous RAM model) and an RD_LAT=3 instance (bench-driven read
// data), followed by randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int RD1  = 1;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;

  logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_we, busy;
  logic [DW-1:0] if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic          if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, mem_we3, busy3;
  logic [DW-1:0] if_rdata3, ls_rdata3, mem_wdata3, mem_rdata3;
  logic [AW-1:0] mem_addr3;

  int checks = 0;
  int errors = 0;

  logic [111:0] all1, all3;
  assign all1 = {if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, mem_addr, mem_wdata, mem_we, busy};
  assign all3 = {if_gnt3, if_rvalid3, if_rdata3, ls_gnt3, ls_rvalid3, ls_rdata3, mem_addr3, mem_wdata3, mem_we3, busy3};

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD1), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .STARVE_MAX(SMAX)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt3), .ls_rvalid(ls_rvalid3), .ls_rdata(ls_rdata3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_we(mem_we3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Synchronous RAM model for the RD_LAT=1 instance, with a bench poke port.
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] ref_mem [0:1023];
  logic          poke_en;
  logic [AW-1:0] poke_addr;
  logic [DW-1:0] poke_data;
  logic [DW-1:0] rd_q;

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    rd_q <= mem[mem_addr];
  end
  assign mem_rdata = rd_q;

  function automatic logic [AW-1:0] addr_of(input int i);
    case (i)
      0: return 10'h000;
      1: return 10'h001;
      2: return 10'h010;
      3: return 10'h155;
      4: return 10'h2AA;
      5: return 10'h3FE;
      6: return 10'h3FF;
      default: return 10'h200;
    endcase
  endfunction

  function automatic logic [AW-1:0] pick_addr();
    return addr_of(int'($urandom_range(0, 7)));
  endfunction

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 8; i++) poke(addr_of(i), $urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if_req = 1'b1; ls_req = 1'b1; ls_we = 1'(k & 1);
      if_addr = pick_addr(); ls_addr = pick_addr(); ls_wdata = $urandom;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (all1 !== 112'd0) begin errors++; $display("FAIL reset_dut1: got %h want 0", all1); end
    checks++;
    if (all3 !== 112'd0) begin errors++; $display("FAIL reset_dut3: got %h want 0", all3); end
    rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
  endtask

  task automatic test_fetch();
    do_reset();
    poke(10'h010, 32'hDEADBEEF);
    if_req = 1'b1; if_addr = 10'h010;
    @(negedge clk);
    checks++;
    if ({if_gnt, ls_gnt, mem_we, busy} !== 4'b1001 || mem_addr !== 10'h010) begin
      errors++; $display("FAIL fetch_issue: got gnt/lsgnt/we/busy=%b addr=%h want 1001 010", {if_gnt, ls_gnt, mem_we, busy}, mem_addr);
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rvalid, busy} !== 2'b01 || mem_addr !== 10'h010) begin
      errors++; $display("FAIL fetch_wait: got rvalid/busy=%b addr=%h want 01 010", {if_rvalid, busy}, mem_addr);
    end
    @(negedge clk);
    checks++;
    if ({if_rvalid, ls_rvalid} !== 2'b10 || if_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL fetch_resp: got rvalid=%b data=%h want 10 deadbeef", {if_rvalid, ls_rvalid}, if_rdata);
    end
    @(negedge clk);
    checks++;
    if ({if_rvalid, busy} !== 2'b00 || if_rdata !== 32'hDEADBEEF || mem_addr !== 10'h000) begin
      errors++; $display("FAIL fetch_after: got rvalid/busy=%b data=%h addr=%h want 00 deadbeef 000", {if_rvalid, busy}, if_rdata, mem_addr);
    end
  endtask

  task automatic test_store();
    do_reset();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 10'h3FF; ls_wdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if ({if_gnt, ls_gnt, mem_we, busy} !== 4'b0111 || mem_addr !== 10'h3FF || mem_wdata !== 32'h12345678) begin
      errors++; $display("FAIL store_issue: got gnt/lsgnt/we/busy=%b addr=%h wdata=%h want 0111 3ff 12345678",
                         {if_gnt, ls_gnt, mem_we, busy}, mem_addr, mem_wdata);
    end
    ls_req = 1'b0; ls_we = 1'b0;
    ref_mem[10'h3FF] = 32'h12345678;
    @(negedge clk);
    checks++;
    if ({ls_gnt, ls_rvalid, mem_we, busy} !== 4'b0000 || mem_addr !== 10'h000 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL store_after: got gnt/rvalid/we/busy=%b addr=%h wdata=%h want 0000 000 0",
                         {ls_gnt, ls_rvalid, mem_we, busy}, mem_addr, mem_wdata);
    end
    checks++;
    if (mem[10'h3FF] !== 32'h12345678) begin errors++; $display("FAIL store_mem: got %h want 12345678", mem[10'h3FF]); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (ls_rvalid !== 1'b0) begin errors++; $display("FAIL store_no_rvalid: got %b want 0", ls_rvalid); end
    end
  endtask

  task automatic test_contention();
    do_reset();
    poke(10'h020, 32'hA5A50020);
    poke(10'h030, 32'h5A5A0030);
    if_req = 1'b1; if_addr = 10'h020;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 10'h030;
    for (int k = 1; k <= 8; k++) begin
      logic [3:0] want;
      @(negedge clk);
      case (k)
        1: want = 4'b0100;
        3: want = 4'b0001;
        5: want = 4'b1000;
        7: want = 4'b0010;
        default: want = 4'b0000;
      endcase
      checks++;
      if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== want) begin
        errors++; $display("FAIL contend_pulses k=%0d: got %b want %b", k, {if_gnt, ls_gnt, if_rvalid, ls_rvalid}, want);
      end
      if (k == 1 || k == 5) begin
        checks++;
        if (mem_addr !== ((k == 1) ? 10'h030 : 10'h020)) begin
          errors++; $display("FAIL contend_addr k=%0d: got %h", k, mem_addr);
        end
      end
      if (k == 3) begin
        checks++;
        if (ls_rdata !== 32'h5A5A0030 || if_rdata !== 32'h0) begin
          errors++; $display("FAIL contend_ls_data: got ls=%h if=%h want 5a5a0030 0", ls_rdata, if_rdata);
        end
      end
      if (k == 7) begin
        checks++;
        if (if_rdata !== 32'hA5A50020 || ls_rdata !== 32'h5A5A0030) begin
          errors++; $display("FAIL contend_if_data: got if=%h ls=%h want a5a50020 5a5a0030", if_rdata, ls_rdata);
        end
      end
      ls_req = 1'b0;
      if (k >= 5) if_req = 1'b0;
    end
  endtask

  task automatic test_starvation();
    int n;
    int got [10];
    do_reset();
    n = 0;
    if_req = 1'b1; if_addr = 10'h020;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 10'h030;
    for (int k = 0; k < 80 && n < 10; k++) begin
      @(negedge clk);
      checks++;
      if (if_gnt === 1'b1 && ls_gnt === 1'b1) begin errors++; $display("FAIL starve_both_gnt: got 11 want not both"); end
      if (if_gnt === 1'b1) begin got[n] = 1; n++; end
      else if (ls_gnt === 1'b1) begin got[n] = 0; n++; end
    end
    if_req = 1'b0; ls_req = 1'b0;
    checks++;
    if (n != 10) begin errors++; $display("FAIL starve_count: got %0d grants want 10", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got[i] != ((i == 4 || i == 9) ? 1 : 0)) begin
        errors++; $display("FAIL starve_order[%0d]: got %s want %s", i, got[i] ? "IF" : "LS", (i == 4 || i == 9) ? "IF" : "LS");
      end
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    poke(10'h155, 32'hC0FFEE55);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 10'h155;
    @(negedge clk);
    checks++;
    if (ls_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt: got %b want 1", ls_gnt); end
    ls_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (all1 !== 112'd0) begin errors++; $display("FAIL rstmid_zero: got %h want 0", all1); end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({if_rvalid, ls_rvalid, busy} !== 3'b000) begin
        errors++; $display("FAIL rstmid_quiet: got %b want 000", {if_rvalid, ls_rvalid, busy});
      end
    end
    ls_req = 1'b1; ls_addr = 10'h155;
    @(negedge clk);
    checks++;
    if (ls_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt2: got %b want 1", ls_gnt); end
    ls_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ls_rvalid !== 1'b1 || ls_rdata !== 32'hC0FFEE55) begin
      errors++; $display("FAIL rstmid_reload: got rvalid=%b data=%h want 1 c0ffee55", ls_rvalid, ls_rdata);
    end
  endtask

  task automatic test_rdlat3();
    do_reset();
    mem_rdata3 = 32'h0;
    if_req = 1'b1; if_addr = 10'h2AA;
    for (int k = 1; k <= 6; k++) begin
      logic ok;
      @(negedge clk);
      case (k)
        1: ok = ({if_gnt3, ls_gnt3, mem_we3, busy3} === 4'b1001) && (mem_addr3 === 10'h2AA);
        2, 3, 4: ok = ({if_gnt3, if_rvalid3, mem_we3, busy3} === 4'b0001) && (mem_addr3 === 10'h2AA);
        5: ok = ({if_rvalid3, ls_rvalid3, busy3} === 3'b101) && (if_rdata3 === 32'hCAFEF00D) && (mem_addr3 === 10'h000);
        default: ok = ({if_rvalid3, busy3} === 2'b00) && (if_rdata3 === 32'hCAFEF00D);
      endcase
      checks++;
      if (!ok) begin
        errors++; $display("FAIL rdlat3 k=%0d: got gnt=%b rvalid=%b we=%b busy=%b addr=%h data=%h",
                           k, if_gnt3, if_rvalid3, mem_we3, busy3, mem_addr3, if_rdata3);
      end
      if_req = 1'b0;
      case (k)
        2: mem_rdata3 = 32'h22222222;
        3: mem_rdata3 = 32'hBAD0BAD0;
        4: mem_rdata3 = 32'hCAFEF00D;
        default: mem_rdata3 = 32'h11111111;
      endcase
    end
  endtask

  // Randomized traffic checked against a transaction-level model: each grant
  // opens a transaction with an issue cycle and an end cycle; expected port
  // values follow from the cycle's position inside that window.
  task automatic test_random(input int pif, input int pls, input int ncyc);
    int cyc, t_iss, t_end, starve;
    logic tv, t_if, t_we, act, in_win, e_we;
    logic [AW-1:0] t_addr, e_addr;
    logic [DW-1:0] t_wd, e_ifr, e_lsr, e_wd;
    logic [3:0] e_pulse;
    init_mem();
    do_reset();
    tv = 1'b0; t_if = 1'b0; t_we = 1'b0; t_addr = '0; t_wd = '0; t_iss = 0; t_end = 0;
    starve = 0; e_ifr = '0; e_lsr = '0; cyc = 0;
    for (int n = 0; n < ncyc; n++) begin
      act = tv && (cyc >= t_iss) && (cyc <= t_end);
      in_win = act && (cyc <= t_iss + (t_we ? 0 : RD1));
      e_pulse = 4'b0000; e_we = 1'b0;
      e_addr = in_win ? t_addr : '0;
      if (act && cyc == t_iss) begin
        e_pulse[3] = t_if; e_pulse[2] = !t_if; e_we = t_we;
      end
      if (act && !t_we && cyc == t_iss + RD1 + 1) begin
        if (t_if) begin e_pulse[1] = 1'b1; e_ifr = ref_mem[t_addr]; end
        else begin e_pulse[0] = 1'b1; e_lsr = ref_mem[t_addr]; end
      end
      checks++;
      if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_we, busy} !== {e_pulse, e_we, act}) begin
        errors++; $display("FAIL rnd_ctrl cyc=%0d: got %b want %b", cyc, {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_we, busy}, {e_pulse, e_we, act});
      end
      checks++;
      if (mem_addr !== e_addr) begin errors++; $display("FAIL rnd_addr cyc=%0d: got %h want %h", cyc, mem_addr, e_addr); end
      checks++;
      if (if_rdata !== e_ifr || ls_rdata !== e_lsr) begin
        errors++; $display("FAIL rnd_rdata cyc=%0d: got if=%h ls=%h want if=%h ls=%h", cyc, if_rdata, ls_rdata, e_ifr, e_lsr);
      end
      if (!in_win || cyc == t_iss) begin
        e_wd = (in_win && !t_if) ? t_wd : '0;
        checks++;
        if (mem_wdata !== e_wd) begin errors++; $display("FAIL rnd_wdata cyc=%0d: got %h want %h", cyc, mem_wdata, e_wd); end
      end
      if_req   = (int'($urandom_range(0, 99)) < pif);
      ls_req   = (int'($urandom_range(0, 99)) < pls);
      ls_we    = 1'($urandom_range(0, 1));
      if_addr  = pick_addr();
      ls_addr  = pick_addr();
      ls_wdata = $urandom;
      if (!act) begin
        if (if_req && (!ls_req || starve == SMAX)) begin
          tv = 1'b1; t_if = 1'b1; t_we = 1'b0; t_addr = if_addr; t_wd = '0;
          starve = 0;
        end else if (ls_req) begin
          tv = 1'b1; t_if = 1'b0; t_we = ls_we; t_addr = ls_addr; t_wd = ls_wdata;
          starve = if_req ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
          if (ls_we) ref_mem[ls_addr] = ls_wdata;
        end else begin
          starve = 0;
        end
        if (if_req || ls_req) begin
          t_iss = cyc + 1;
          t_end = t_iss + (t_we ? 0 : RD1 + 1);
        end
      end
      @(negedge clk);
      cyc++;
    end
    if_req = 1'b0; ls_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0; mem_rdata3 = '0;
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_starvation();
    test_reset_mid();
    test_rdlat3();
    test_random(60, 60, 300);
    test_random(90, 90, 200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
